// File: rtl/nx_mesh_sequencer_if.sv
// Handshake and status bundle between host-side control logic and the mesh sequencer.
interface nx_mesh_sequencer_if #(
  parameter int COLUMNS     = 3,
  parameter int COUNT_WIDTH = 16
);
  logic                   start_i;
  logic                   stop_i;
  logic                   single_step_i;
  logic [COUNT_WIDTH-1:0] cycle_limit_i;
  logic [COUNT_WIDTH-1:0] gap_i;
  logic [COLUMNS-1:0]     column_mask_i;
  logic                   mesh_idle_i;
  logic                   mesh_trigger_o;
  logic [COLUMNS-1:0]     token_grant_o;
  logic [COLUMNS-1:0]     token_release_i;
  logic                   status_active_o;
  logic                   status_idle_o;
  logic                   status_trigger_o;
  logic [COUNT_WIDTH-1:0] cycle_count_o;
  logic                   done_o;
  logic                   error_o;

  modport master (
    output start_i, stop_i, single_step_i, cycle_limit_i, gap_i, column_mask_i,
           mesh_idle_i, token_release_i,
    input  mesh_trigger_o, token_grant_o, status_active_o, status_idle_o,
           status_trigger_o, cycle_count_o, done_o, error_o
  );

  modport slave (
    input  start_i, stop_i, single_step_i, cycle_limit_i, gap_i, column_mask_i,
           mesh_idle_i, token_release_i,
    output mesh_trigger_o, token_grant_o, status_active_o, status_idle_o,
           status_trigger_o, cycle_count_o, done_o, error_o
  );
endinterface

// File: rtl/nx_mesh_sequencer.sv
// Mesh cycle engine: trigger, per-column token grant, release collection, gap and run control.
//   state     | meaning
//   S_IDLE    | no run in progress, waiting for start_i
//   S_TRIGGER | one-cycle trigger pulse to the mesh
//   S_GRANT   | one-cycle token grant to the enabled columns
//   S_WAIT    | collecting releases until all tokens back and mesh idle
//   S_GAP     | programmable idle spacing before the next trigger
module nx_mesh_sequencer #(
  parameter int COLUMNS     = 3,
  parameter int COUNT_WIDTH = 16
) (
  input logic                clk_i,
  input logic                rst_i,
  nx_mesh_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIGGER,
    S_GRANT,
    S_WAIT,
    S_GAP
  } state_t;

  state_t                 state_q, state_nx;
  logic [COLUMNS-1:0]     mask_q;
  logic [COLUMNS-1:0]     pending_q;
  logic [COUNT_WIDTH-1:0] limit_q;
  logic [COUNT_WIDTH-1:0] cycle_q;
  logic [COUNT_WIDTH-1:0] gap_cnt_q;
  logic                   stop_q;
  logic                   trig_q;
  logic [COLUMNS-1:0]     grant_q;
  logic                   active_q;
  logic                   done_q;
  logic                   error_q;

  logic                   accept;
  logic                   stop_seen;
  logic                   end_run;
  logic [COLUMNS-1:0]     live_pending;
  logic                   rel_err;
  logic                   busy_start;

  assign accept       = (state_q == S_IDLE) && bus.start_i;
  assign stop_seen    = stop_q || bus.stop_i;
  assign end_run      = stop_seen || bus.single_step_i ||
                        ((limit_q != '0) && (cycle_q == limit_q));
  // Only WAIT holds outstanding tokens; any release elsewhere is unsolicited.
  assign live_pending = (state_q == S_WAIT) ? pending_q : '0;
  assign rel_err      = |(bus.token_release_i & ~live_pending);
  assign busy_start   = (state_q != S_IDLE) && bus.start_i;

  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE:    if (bus.start_i) state_nx = S_TRIGGER;
      S_TRIGGER: state_nx = S_GRANT;
      S_GRANT:   state_nx = S_WAIT;
      S_WAIT: begin
        if ((pending_q == '0) && bus.mesh_idle_i) begin
          if (end_run)                state_nx = S_IDLE;
          else if (bus.gap_i != '0)   state_nx = S_GAP;
          else                        state_nx = S_TRIGGER;
        end
      end
      S_GAP: begin
        if (stop_seen)                               state_nx = S_IDLE;
        else if (gap_cnt_q == COUNT_WIDTH'(1))       state_nx = S_TRIGGER;
      end
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      pending_q <= '0;
      limit_q   <= '0;
      cycle_q   <= '0;
      gap_cnt_q <= '0;
      stop_q    <= 1'b0;
      trig_q    <= 1'b0;
      grant_q   <= '0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q  <= state_nx;
      trig_q   <= (state_nx == S_TRIGGER);
      grant_q  <= (state_nx == S_GRANT) ? mask_q : '0;
      active_q <= (state_nx != S_IDLE);
      done_q   <= (state_q != S_IDLE) && (state_nx == S_IDLE);

      if (accept) begin
        cycle_q <= '0;
        mask_q  <= bus.column_mask_i;
        limit_q <= bus.cycle_limit_i;
        stop_q  <= 1'b0;
      end else begin
        if (state_q == S_TRIGGER)              cycle_q <= cycle_q + COUNT_WIDTH'(1);
        if ((state_q != S_IDLE) && bus.stop_i) stop_q  <= 1'b1;
      end

      if (state_q == S_GRANT)      pending_q <= mask_q;
      else if (state_q == S_WAIT)  pending_q <= pending_q & ~bus.token_release_i;
      else                         pending_q <= '0;

      if ((state_q == S_WAIT) && (state_nx == S_GAP)) gap_cnt_q <= bus.gap_i;
      else if (state_q == S_GAP)                      gap_cnt_q <= gap_cnt_q - COUNT_WIDTH'(1);

      // A new run clears the sticky flag, but a violation in the same cycle still wins.
      error_q <= (accept ? 1'b0 : error_q) | rel_err | busy_start;
    end
  end

  assign bus.mesh_trigger_o   = trig_q;
  assign bus.status_trigger_o = trig_q;
  assign bus.token_grant_o    = grant_q;
  assign bus.status_active_o  = active_q;
  assign bus.status_idle_o    = (state_q == S_IDLE) && bus.mesh_idle_i;
  assign bus.cycle_count_o    = cycle_q;
  assign bus.done_o           = done_q;
  assign bus.error_o          = error_q;

endmodule

// File: tb/tb_nx_mesh_sequencer.sv
// Directed bench for nx_mesh_sequencer; expected run results are queued and checked at each done_o.
module tb_nx_mesh_sequencer;
  localparam int COLS = 3;
  localparam int CW   = 8;   // narrow counter keeps the wrap and full-limit runs short

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nx_mesh_sequencer_if #(.COLUMNS(COLS), .COUNT_WIDTH(CW)) bus();

  nx_mesh_sequencer #(.COLUMNS(COLS), .COUNT_WIDTH(CW)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  logic [COLS-1:0] auto_rel  = '0;
  logic [COLS-1:0] man_rel   = '0;
  logic [COLS-1:0] hold_cols = '0;
  assign bus.token_release_i = auto_rel | man_rel;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              cnt;
    logic            err;
    int              trigs;
    logic [COLS-1:0] grants;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int cnt, input logic err, input int trigs,
                          input logic [COLS-1:0] grants);
    exp_t e;
    e.cnt = cnt; e.err = err; e.trigs = trigs; e.grants = grants;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Mesh model: returns every granted, non-held column in the cycle after the grant.
  initial begin
    logic [COLS-1:0] g;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.token_grant_o != '0)) begin
        g = bus.token_grant_o & ~hold_cols;
        @(posedge clk); #1 auto_rel = g;
        @(posedge clk); #1 auto_rel = '0;
      end
    end
  end

  // Monitor: accumulates per-run activity and scores it against the queue on done_o.
  int              trig_run  = 0;
  logic [COLS-1:0] grant_acc = '0;
  int              trig_t0   = 0;
  int              trig_t1   = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        trig_run  = 0;
        grant_acc = '0;
      end else begin
        if (bus.mesh_trigger_o) begin
          trig_run++;
          trig_t0 = trig_t1;
          trig_t1 = cyc;
        end
        grant_acc |= bus.token_grant_o;
        if (bus.done_o) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done actual=1 required=0");
          end else begin
            e = sb_q.pop_front();
            chk("run_count",      32'(bus.cycle_count_o), e.cnt);
            chk("run_error",      32'(bus.error_o),       32'(e.err));
            chk("run_trigs",      trig_run,               e.trigs);
            chk("run_grants",     32'(grant_acc),         32'(e.grants));
            chk("active_at_done", 32'(bus.status_active_o), 0);
          end
          trig_run  = 0;
          grant_acc = '0;
        end
      end
    end
  end

  task automatic do_start(input logic [COLS-1:0] mask, input logic [CW-1:0] limit,
                          input logic [CW-1:0] gap, input logic step);
    tick();
    bus.column_mask_i = mask;
    bus.cycle_limit_i = limit;
    bus.gap_i         = gap;
    bus.single_step_i = step;
    bus.start_i       = 1'b1;
    tick();
    bus.start_i = 1'b0;
    @(negedge clk);
    chk("lat_trigger",  32'(bus.mesh_trigger_o),   1);
    chk("lat_status_trig", 32'(bus.status_trigger_o), 1);
    chk("lat_active",   32'(bus.status_active_o),  1);
    chk("lat_error_clr", 32'(bus.error_o),         0);
    @(negedge clk);
    chk("lat_grant",    32'(bus.token_grant_o),    32'(mask));
    chk("lat_trig_low", 32'(bus.mesh_trigger_o),   0);
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (bus.done_o) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=0 required=1", name);
    end
  endtask

  initial begin
    bit saw;
    int seen_trig;
    bus.start_i       = 1'b0;
    bus.stop_i        = 1'b0;
    bus.single_step_i = 1'b0;
    bus.cycle_limit_i = '0;
    bus.gap_i         = '0;
    bus.column_mask_i = '0;
    bus.mesh_idle_i   = 1'b1;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_trigger", 32'(bus.mesh_trigger_o),  0);
    chk("rst_grant",   32'(bus.token_grant_o),   0);
    chk("rst_active",  32'(bus.status_active_o), 0);
    chk("rst_done",    32'(bus.done_o),          0);
    chk("rst_error",   32'(bus.error_o),         0);
    chk("rst_count",   32'(bus.cycle_count_o),   0);
    chk("idle_high",   32'(bus.status_idle_o),   1);
    bus.mesh_idle_i = 1'b0; #1;
    chk("idle_low",    32'(bus.status_idle_o),   0);
    bus.mesh_idle_i = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    // two-cycle limited run, trigger cycles N+1 and N+5
    push_exp(2, 1'b0, 2, 3'b111);
    do_start(3'b111, 8'd2, 8'd0, 1'b0);
    wait_done(60, "limit2");
    chk("trig_spacing", trig_t1 - trig_t0, 4);

    // gap of 3 lengthens the period to 7
    push_exp(2, 1'b0, 2, 3'b001);
    do_start(3'b001, 8'd2, 8'd3, 1'b0);
    wait_done(60, "gap3");
    chk("gap_spacing", trig_t1 - trig_t0, 7);

    // single step, twice
    push_exp(1, 1'b0, 1, 3'b101);
    do_start(3'b101, 8'd0, 8'd0, 1'b1);
    wait_done(30, "step1");
    push_exp(1, 1'b0, 1, 3'b101);
    do_start(3'b101, 8'd0, 8'd0, 1'b1);
    wait_done(30, "step2");
    bus.single_step_i = 1'b0;

    // stop in WAIT with column 1 outstanding: no abort
    hold_cols = 3'b010;
    push_exp(1, 1'b0, 1, 3'b111);
    do_start(3'b111, 8'd0, 8'd3, 1'b0);
    repeat (3) tick();
    bus.stop_i = 1'b1;
    tick();
    bus.stop_i = 1'b0;
    saw = 1'b0;
    repeat (5) begin @(negedge clk); if (bus.done_o) saw = 1'b1; end
    chk("no_abort_done",   32'(saw), 0);
    chk("no_abort_active", 32'(bus.status_active_o), 1);
    tick();
    bus.mesh_idle_i = 1'b0;
    man_rel = 3'b010;
    tick();
    man_rel = '0;
    saw = 1'b0;
    repeat (3) begin @(negedge clk); if (bus.done_o) saw = 1'b1; end
    chk("held_by_mesh_busy", 32'(saw), 0);
    tick();
    bus.mesh_idle_i = 1'b1;
    wait_done(10, "stop_wait");
    saw = 1'b0;
    repeat (6) begin @(negedge clk); if (bus.mesh_trigger_o) saw = 1'b1; end
    chk("no_trigger_after_stop", 32'(saw), 0);
    hold_cols = '0;

    // stop while in GAP
    push_exp(1, 1'b0, 1, 3'b010);
    do_start(3'b010, 8'd0, 8'd5, 1'b0);
    repeat (3) tick();
    bus.stop_i = 1'b1;
    tick();
    bus.stop_i = 1'b0;
    wait_done(4, "stop_gap");

    // release while idle
    tick();
    man_rel = 3'b100;
    tick();
    man_rel = '0;
    @(negedge clk);
    chk("err_idle_release", 32'(bus.error_o), 1);
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'(bus.error_o), 1);
    push_exp(1, 1'b0, 1, 3'b111);
    do_start(3'b111, 8'd1, 8'd0, 1'b0);
    wait_done(30, "err_clear_run");

    // release of a column outside the mask
    push_exp(1, 1'b1, 1, 3'b001);
    do_start(3'b001, 8'd1, 8'd0, 1'b0);
    tick();
    man_rel = 3'b100;
    tick();
    man_rel = '0;
    @(negedge clk);
    chk("err_unmasked_release", 32'(bus.error_o), 1);
    wait_done(20, "err_mask_run");
    repeat (3) @(negedge clk);
    chk("err_hold_after_done", 32'(bus.error_o), 1);

    // start while busy is flagged and ignored
    push_exp(3, 1'b1, 3, 3'b111);
    do_start(3'b111, 8'd3, 8'd0, 1'b0);
    tick();
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    wait_done(60, "busy_start");

    // reset mid-WAIT with tokens outstanding
    hold_cols = 3'b011;
    do_start(3'b011, 8'd0, 8'd0, 1'b0);
    tick();
    chk("pre_reset_count", 32'(bus.cycle_count_o), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_trigger", 32'(bus.mesh_trigger_o),  0);
    chk("mid_rst_grant",   32'(bus.token_grant_o),   0);
    chk("mid_rst_active",  32'(bus.status_active_o), 0);
    chk("mid_rst_done",    32'(bus.done_o),          0);
    chk("mid_rst_error",   32'(bus.error_o),         0);
    chk("mid_rst_count",   32'(bus.cycle_count_o),   0);
    tick();
    tick();
    rst_n     = 1'b1;
    hold_cols = '0;
    push_exp(1, 1'b0, 1, 3'b011);
    do_start(3'b011, 8'd1, 8'd0, 1'b0);
    wait_done(20, "post_reset_run");

    // full-range limit
    push_exp(255, 1'b0, 255, 3'b000);
    do_start(3'b000, 8'hFF, 8'd0, 1'b0);
    wait_done(1200, "limit_max");

    // unbounded run stopped after 256 cycles wraps the count
    push_exp(0, 1'b0, 256, 3'b000);
    do_start(3'b000, 8'd0, 8'd0, 1'b0);
    seen_trig = 1;
    for (int n = 0; n < 1200 && seen_trig < 256; n++) begin
      @(negedge clk);
      if (bus.mesh_trigger_o) seen_trig++;
    end
    chk("wrap_trig_reached", seen_trig, 256);
    tick();
    bus.stop_i = 1'b1;
    tick();
    bus.stop_i = 1'b0;
    wait_done(10, "wrap_stop");

    repeat (5) tick();
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=1 required=0");
    $fatal(1, "bench time limit");
  end

endmodule
